// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap sequencer:
// CSR addresses, mstatus field positions, cause codes and FSM states.
package trap_pkg;

  localparam int unsigned CSR_ADDR_W = 12;

  localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_ADDR_W-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE  = 12'h342;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam logic [63:0] CAUSE_ECALL_M = 64'd11;
  localparam logic [63:0] CAUSE_MTIMER  = 64'h8000_0000_0000_0007;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    T_RD_ST = 4'd1,
    T_WR_EC = 4'd2,
    T_WR_ST = 4'd3,
    T_RD_TV = 4'd4,
    M_RD_ST = 4'd5,
    M_WR_ST = 4'd6,
    M_RD_EP = 4'd7,
    REDIR   = 4'd8
  } trap_state_e;

endpackage

// File: rtl/trap_status_upd.sv
// Combinational mstatus transform for trap entry and mret.
// Ports:
//   status_in - current mstatus value
//   is_mret   - 1: mret transform, 0: trap-entry transform
//   status_c  - updated mstatus value (combinational)
module trap_status_upd
  import trap_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] status_in,
  input  logic            is_mret,
  output logic [XLEN-1:0] status_c
);

  // Both directions return to machine mode, so MPP is always forced to M.
  always_comb begin
    status_c = status_in;
    status_c[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    if (is_mret) begin
      status_c[MSTATUS_MIE]  = status_in[MSTATUS_MPIE];
      status_c[MSTATUS_MPIE] = 1'b1;
    end else begin
      status_c[MSTATUS_MPIE] = status_in[MSTATUS_MIE];
      status_c[MSTATUS_MIE]  = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer. Accepts timer interrupts, ecall and mret at
// the commit point, walks the CSR file through the save/restore sequence,
// stalls the pipeline meanwhile and ends with a one-cycle PC redirect.
// Ports:
//   clock, reset               - clock, synchronous active-high reset
//   inst_valid/inst_pc         - committing instruction and its PC
//   ecall_valid/mret_valid     - commit-stage instruction type
//   timer_interrupt            - pending timer interrupt
//   csr_rdata                  - combinational CSR read data
//   csr_ren/csr_raddr          - CSR read port
//   csr_wen/waddr1/wdata1      - CSR write port 1
//   csr_wen2/waddr2/wdata2     - CSR write port 2
//   stall                      - freeze pipeline / squash commit
//   redirect_valid/redirect_pc - fetch redirect strobe and target
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned CSR_AW        = 12,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inst_valid,
  input  logic [XLEN-1:0]   inst_pc,
  input  logic              ecall_valid,
  input  logic              mret_valid,
  input  logic              timer_interrupt,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic              csr_ren,
  output logic [CSR_AW-1:0] csr_raddr,
  output logic              csr_wen,
  output logic [CSR_AW-1:0] csr_waddr1,
  output logic [XLEN-1:0]   csr_wdata1,
  output logic              csr_wen2,
  output logic [CSR_AW-1:0] csr_waddr2,
  output logic [XLEN-1:0]   csr_wdata2,
  output logic              stall,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc
);

  localparam int unsigned SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] status_q, status_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            mie_shadow_q, mie_shadow_d;
  logic [SW-1:0]   settle_cnt_q, settle_cnt_d;

  logic [XLEN-1:0] status_new;
  logic            is_mret;
  logic            int_ok;

  assign is_mret = (state_q == M_WR_ST);

  trap_status_upd #(.XLEN(XLEN)) u_status_upd (
    .status_in (status_q),
    .is_mret   (is_mret),
    .status_c  (status_new)
  );

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      epc_q        <= '0;
      cause_q      <= '0;
      status_q     <= '0;
      tgt_q        <= '0;
      mie_shadow_q <= 1'b1;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      status_q     <= status_d;
      tgt_q        <= tgt_d;
      mie_shadow_q <= mie_shadow_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  // Next-state and CSR port drive.
  always_comb begin
    state_d      = state_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    status_d     = status_q;
    tgt_d        = tgt_q;
    mie_shadow_d = mie_shadow_q;
    settle_cnt_d = (settle_cnt_q != '0) ? settle_cnt_q - SW'(1) : '0;

    csr_ren        = 1'b0;
    csr_raddr      = '0;
    csr_wen        = 1'b0;
    csr_waddr1     = '0;
    csr_wdata1     = '0;
    csr_wen2       = 1'b0;
    csr_waddr2     = '0;
    csr_wdata2     = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // The CSR file's MIE is only visible to us through mie_shadow, and a
    // fresh mstatus write needs time to reach timer_interrupt.
    int_ok = timer_interrupt & inst_valid & mie_shadow_q & (settle_cnt_q == '0);

    unique case (state_q)
      IDLE: begin
        if (int_ok) begin
          stall   = 1'b1;
          epc_d   = inst_pc;
          cause_d = XLEN'(CAUSE_MTIMER);
          state_d = T_RD_ST;
        end else if (inst_valid & ecall_valid) begin
          stall   = 1'b1;
          epc_d   = inst_pc;
          cause_d = XLEN'(CAUSE_ECALL_M);
          state_d = T_RD_ST;
        end else if (inst_valid & mret_valid) begin
          stall   = 1'b1;
          epc_d   = inst_pc;
          state_d = M_RD_ST;
        end
      end
      T_RD_ST: begin
        stall     = 1'b1;
        csr_ren   = 1'b1;
        csr_raddr = CSR_AW'(CSR_MSTATUS);
        status_d  = csr_rdata;
        state_d   = T_WR_EC;
      end
      T_WR_EC: begin
        stall      = 1'b1;
        csr_wen    = 1'b1;
        csr_waddr1 = CSR_AW'(CSR_MEPC);
        csr_wdata1 = epc_q;
        csr_wen2   = 1'b1;
        csr_waddr2 = CSR_AW'(CSR_MCAUSE);
        csr_wdata2 = cause_q;
        state_d    = T_WR_ST;
      end
      T_WR_ST: begin
        stall        = 1'b1;
        csr_wen      = 1'b1;
        csr_waddr1   = CSR_AW'(CSR_MSTATUS);
        csr_wdata1   = status_new;
        mie_shadow_d = 1'b0;
        settle_cnt_d = SW'(SETTLE_CYCLES);
        state_d      = T_RD_TV;
      end
      T_RD_TV: begin
        // Direct mode only: low mode bits of mtvec are dropped.
        stall     = 1'b1;
        csr_ren   = 1'b1;
        csr_raddr = CSR_AW'(CSR_MTVEC);
        tgt_d     = {csr_rdata[XLEN-1:2], 2'b00};
        state_d   = REDIR;
      end
      M_RD_ST: begin
        stall     = 1'b1;
        csr_ren   = 1'b1;
        csr_raddr = CSR_AW'(CSR_MSTATUS);
        status_d  = csr_rdata;
        state_d   = M_WR_ST;
      end
      M_WR_ST: begin
        stall        = 1'b1;
        csr_wen      = 1'b1;
        csr_waddr1   = CSR_AW'(CSR_MSTATUS);
        csr_wdata1   = status_new;
        mie_shadow_d = status_q[MSTATUS_MPIE];
        settle_cnt_d = SW'(SETTLE_CYCLES);
        state_d      = M_RD_EP;
      end
      M_RD_EP: begin
        stall     = 1'b1;
        csr_ren   = 1'b1;
        csr_raddr = CSR_AW'(CSR_MEPC);
        tgt_d     = {csr_rdata[XLEN-1:2], 2'b00};
        state_d   = REDIR;
      end
      REDIR: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = tgt_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset aborts at once: nothing reaches the CSR file or the pipeline.
    if (reset) begin
      csr_ren        = 1'b0;
      csr_raddr      = '0;
      csr_wen        = 1'b0;
      csr_waddr1     = '0;
      csr_wdata1     = '0;
      csr_wen2       = 1'b0;
      csr_waddr2     = '0;
      csr_wdata2     = '0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
    end
  end

endmodule
